// File: rtl/reg_port_arbiter.sv
// Shared W-bit register with two write ports and one read port behind a req/ack arbiter.
// Reads win unless writes have waited STARVE read grants; tied writers alternate.
module reg_port_arbiter #(
    parameter int W      = 8,
    parameter int STARVE = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_req1,
    input  logic [W-1:0] wr_data1,
    output logic         wr_ack1,
    input  logic         wr_req2,
    input  logic [W-1:0] wr_data2,
    output logic         wr_ack2,
    input  logic         rd_req,
    output logic [W-1:0] rd_data,
    output logic         rd_ack,
    output logic [W-1:0] q,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, WR1, WR2, RD} state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE);

    state_t         state_reg;
    logic [W-1:0]   store_reg;
    logic [W-1:0]   rd_data_reg;
    logic           last_wr_reg;    // 0: writer 1 served last, 1: writer 2 served last
    logic [3:0]     starve_reg;
    logic           wr_ack1_reg;
    logic           wr_ack2_reg;
    logic           rd_ack_reg;
    logic           busy_reg;

    logic           wr_pend;
    logic           rd_win;
    logic           pick2;

    assign wr_pend = wr_req1 | wr_req2;
    assign rd_win  = rd_req && (!wr_pend || (starve_reg < STARVE_MAX));
    // On a tie writer 2 goes only if writer 1 was the last one served.
    assign pick2   = wr_req2 && (!wr_req1 || !last_wr_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            store_reg   <= '0;
            rd_data_reg <= '0;
            last_wr_reg <= 1'b1;
            starve_reg  <= 4'd0;
            wr_ack1_reg <= 1'b0;
            wr_ack2_reg <= 1'b0;
            rd_ack_reg  <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            wr_ack1_reg <= 1'b0;
            wr_ack2_reg <= 1'b0;
            rd_ack_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rd_win) begin
                        state_reg   <= RD;
                        rd_data_reg <= store_reg;
                        rd_ack_reg  <= 1'b1;
                        busy_reg    <= 1'b1;
                        if (!wr_pend)
                            starve_reg <= 4'd0;
                        else if (starve_reg < STARVE_MAX)
                            starve_reg <= starve_reg + 4'd1;
                    end else if (wr_pend) begin
                        busy_reg    <= 1'b1;
                        starve_reg  <= 4'd0;
                        last_wr_reg <= pick2;
                        if (pick2) begin
                            state_reg   <= WR2;
                            store_reg   <= wr_data2;
                            wr_ack2_reg <= 1'b1;
                        end else begin
                            state_reg   <= WR1;
                            store_reg   <= wr_data1;
                            wr_ack1_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign wr_ack1 = wr_ack1_reg;
    assign wr_ack2 = wr_ack2_reg;
    assign rd_ack  = rd_ack_reg;
    assign rd_data = rd_data_reg;
    assign q       = store_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: directed scenarios plus random requesters checked
// against a transaction-level model of the arbitration rules.
module tb_reg_port_arbiter;

    localparam int W      = 8;
    localparam int STARVE = 3;

    logic         clk;
    logic         rst;
    logic         wr_req1, wr_req2, rd_req;
    logic [W-1:0] wr_data1, wr_data2;
    logic         wr_ack1, wr_ack2, rd_ack, busy;
    logic [W-1:0] rd_data, q;

    int checks = 0;
    int passes = 0;

    reg_port_arbiter #(.W(W), .STARVE(STARVE)) dut (
        .clk(clk), .rst(rst),
        .wr_req1(wr_req1), .wr_data1(wr_data1), .wr_ack1(wr_ack1),
        .wr_req2(wr_req2), .wr_data2(wr_data2), .wr_ack2(wr_ack2),
        .rd_req(rd_req), .rd_data(rd_data), .rd_ack(rd_ack),
        .q(q), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_req1 = 1'b0; wr_req2 = 1'b0; rd_req = 1'b0;
        wr_data1 = '0;  wr_data2 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (q !== 8'h00) $display("FAIL reset_q got=%h want=00", q); else passes++;
        checks++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got=%h want=00", rd_data); else passes++;
        checks++; if ({wr_ack1, wr_ack2, rd_ack, busy} !== 4'b0000)
            $display("FAIL reset_flags got=%b want=0000", {wr_ack1, wr_ack2, rd_ack, busy}); else passes++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        do_reset();
        wr_req1 = 1'b1; wr_data1 = 8'hA5;
        tick();
        $display("txn wr1 data=%h", wr_data1);
        checks++; if (wr_ack1 !== 1'b1 || busy !== 1'b1) $display("FAIL wr1_ack got=%b%b want=11", wr_ack1, busy); else passes++;
        checks++; if (q !== 8'hA5) $display("FAIL wr1_q got=%h want=a5", q); else passes++;
        wr_req1 = 1'b0;
        tick();
        checks++; if (wr_ack1 !== 1'b0 || busy !== 1'b0) $display("FAIL wr1_drop got=%b%b want=00", wr_ack1, busy); else passes++;
        rd_req = 1'b1;
        tick();
        $display("txn rd data=%h", rd_data);
        checks++; if (rd_ack !== 1'b1 || rd_data !== 8'hA5)
            $display("FAIL rd_after_wr got=%b/%h want=1/a5", rd_ack, rd_data); else passes++;
        rd_req = 1'b0;
        tick();
    endtask

    // Holds both writers until acked and reports the ack order.
    task automatic serve_both(output int first, output int second, output int n);
        int order[2];
        order[0] = 0; order[1] = 0;
        n = 0;
        for (int c = 0; c < 12 && n < 2; c++) begin
            tick();
            if (wr_ack1) begin
                $display("txn wr1 data=%h", wr_data1);
                order[n] = 1; n++; wr_req1 = 1'b0;
            end
            if (wr_ack2 && n < 2) begin
                $display("txn wr2 data=%h", wr_data2);
                order[n] = 2; n++; wr_req2 = 1'b0;
            end
        end
        first = order[0];
        second = order[1];
        tick();
    endtask

    task automatic test_tie();
        int f, s, n;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            wr_req1 = 1'b1; wr_data1 = 8'h11;
            wr_req2 = 1'b1; wr_data2 = 8'h22;
            serve_both(f, s, n);
            checks++; if (n !== 2 || f !== 1 || s !== 2)
                $display("FAIL tie_order round=%0d got=%0d,%0d (n=%0d) want=1,2", r, f, s, n); else passes++;
            checks++; if (q !== 8'h22) $display("FAIL tie_q round=%0d got=%h want=22", r, q); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int d = 1; d <= 3; d++) begin
            wr_req2 = 1'b1; wr_data2 = 8'(d);
            tick();
            $display("txn wr2 data=%h", wr_data2);
            checks++; if (wr_ack2 !== 1'b1 || q !== 8'(d))
                $display("FAIL b2b_wr2 d=%0d got=%b/%h want=1/%h", d, wr_ack2, q, 8'(d)); else passes++;
            wr_req2 = 1'b0;
            tick();
        end
        wr_req1 = 1'b1; wr_data1 = 8'h33;
        wr_req2 = 1'b1; wr_data2 = 8'h44;
        tick();
        checks++; if (wr_ack1 !== 1'b1 || wr_ack2 !== 1'b0 || q !== 8'h33)
            $display("FAIL b2b_tie got=%b%b/%h want=10/33", wr_ack1, wr_ack2, q); else passes++;
        wr_req1 = 1'b0;
        tick();
        tick();
        checks++; if (wr_ack2 !== 1'b1 || q !== 8'h44)
            $display("FAIL b2b_tie_second got=%b/%h want=1/44", wr_ack2, q); else passes++;
        wr_req2 = 1'b0;
        tick();
    endtask

    task automatic test_starve();
        int reads_before = 0;
        int wr_seen = 0;
        int after = -1;
        do_reset();
        rd_req = 1'b1;
        wr_req1 = 1'b1; wr_data1 = 8'h5A;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (rd_ack) begin
                $display("txn rd data=%h", rd_data);
                if (wr_seen == 0) reads_before++;
                else begin after = int'(rd_data); break; end
            end
            if (wr_ack1) begin
                $display("txn wr1 data=%h", wr_data1);
                wr_seen = 1; wr_req1 = 1'b0;
            end
        end
        rd_req = 1'b0;
        tick();
        checks++; if (reads_before !== STARVE) $display("FAIL starve_reads got=%0d want=%0d", reads_before, STARVE); else passes++;
        checks++; if (wr_seen !== 1) $display("FAIL starve_write got=%0d want=1", wr_seen); else passes++;
        checks++; if (after !== 32'h5A) $display("FAIL starve_read_after got=%0h want=5a", after); else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr_req1 = 1'b1; wr_data1 = 8'h77;
        tick();
        wr_req1 = 1'b0;
        tick();
        rd_req = 1'b1;
        tick();
        checks++; if (rd_data !== 8'h77) $display("FAIL mid_pre_read got=%h want=77", rd_data); else passes++;
        rd_req = 1'b0;
        tick();
        wr_req2 = 1'b1; wr_data2 = 8'hFF;
        tick();
        checks++; if (wr_ack2 !== 1'b1) $display("FAIL mid_pre_ack got=%b want=1", wr_ack2); else passes++;
        #2 rst = 1'b0;
        #1;
        checks++; if (wr_ack2 !== 1'b0 || busy !== 1'b0) $display("FAIL mid_ack_drop got=%b%b want=00", wr_ack2, busy); else passes++;
        checks++; if (q !== 8'h00 || rd_data !== 8'h00)
            $display("FAIL mid_clear got=%h/%h want=00/00", q, rd_data); else passes++;
        #1 rst = 1'b1;
        tick();
        checks++; if (wr_ack2 !== 1'b1 || q !== 8'hFF)
            $display("FAIL mid_regrant got=%b/%h want=1/ff", wr_ack2, q); else passes++;
        wr_req2 = 1'b0;
        tick();
    endtask

    task automatic test_idle();
        logic [W-1:0] held;
        clear_inputs();
        tick();
        held = q;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if ({wr_ack1, wr_ack2, rd_ack, busy} !== 4'b0000 || q !== held)
                $display("FAIL idle c=%0d got=%b/%h want=0000/%h", c, {wr_ack1, wr_ack2, rd_ack, busy}, q, held); else passes++;
        end
    endtask

    // Random requesters against a model that decides one grant per transaction slot.
    task automatic test_random();
        int m_q = 0, m_rd = 0, m_last = 2, m_starve = 0;
        bit m_gap = 0;
        int who;
        bit e_a1, e_a2, e_ar;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            e_a1 = 0; e_a2 = 0; e_ar = 0;
            if (m_gap) m_gap = 0;
            else if (rd_req && (!(wr_req1 || wr_req2) || m_starve < STARVE)) begin
                m_rd = m_q;
                m_starve = (wr_req1 || wr_req2) ? ((m_starve + 1 > STARVE) ? STARVE : m_starve + 1) : 0;
                e_ar = 1; m_gap = 1;
            end else if (wr_req1 || wr_req2) begin
                if (wr_req1 && wr_req2) who = 3 - m_last;
                else who = wr_req1 ? 1 : 2;
                m_q = (who == 1) ? int'(wr_data1) : int'(wr_data2);
                m_last = who; m_starve = 0; m_gap = 1;
                if (who == 1) e_a1 = 1; else e_a2 = 1;
            end
            tick();
            if (rd_ack) $display("txn rd data=%h", rd_data);
            if (wr_ack1) $display("txn wr1 data=%h", q);
            if (wr_ack2) $display("txn wr2 data=%h", q);
            checks++;
            if ({wr_ack1, wr_ack2, rd_ack, busy} !== {e_a1, e_a2, e_ar, m_gap} || q !== 8'(m_q) || rd_data !== 8'(m_rd))
                $display("FAIL random c=%0d got=%b/%h/%h want=%b/%h/%h", c, {wr_ack1, wr_ack2, rd_ack, busy}, q, rd_data,
                         {e_a1, e_a2, e_ar, m_gap}, 8'(m_q), 8'(m_rd));
            else passes++;
            if (wr_ack1) begin
                wr_req1 = 1'($urandom_range(0, 1)); wr_data1 = 8'($urandom);
            end else if (!wr_req1 && $urandom_range(0, 2) == 0) begin
                wr_req1 = 1'b1; wr_data1 = 8'($urandom);
            end
            if (wr_ack2) begin
                wr_req2 = 1'($urandom_range(0, 1)); wr_data2 = 8'($urandom);
            end else if (!wr_req2 && $urandom_range(0, 2) == 0) begin
                wr_req2 = 1'b1; wr_data2 = 8'($urandom);
            end
            if (rd_ack) rd_req = ($urandom_range(0, 3) != 0);
            else if (!rd_req && $urandom_range(0, 1) == 0) rd_req = 1'b1;
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_back_to_back();
        test_starve();
        test_reset_mid();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
